// File: rtl/state_reader.sv
// state_reader: small state array with a one-deep, back-pressured read response register.
// Optional STATE_READER_BYPASS_EN forwards a same-index, same-cycle write to the read.
module state_reader #(
    parameter int COUNT_WIDTH = 3,
    parameter int ADDR_WIDTH  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i__wr_valid,
    input  logic [ADDR_WIDTH-1:0]  i__wr_addr,
    input  logic [COUNT_WIDTH-1:0] i__wr_data,
    input  logic                   i__rd_valid,
    input  logic [ADDR_WIDTH-1:0]  i__rd_addr,
    output logic                   o__rd_ready,
    output logic                   o__rsp_valid,
    output logic [COUNT_WIDTH-1:0] o__rsp_data,
    input  logic                   i__rsp_ready,
    output logic [COUNT_WIDTH-1:0] o__rsp_count
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [COUNT_WIDTH-1:0] mem [DEPTH];
    logic                   accept;
    logic                   consume;
    logic [COUNT_WIDTH-1:0] rd_word;

    assign o__rd_ready = !o__rsp_valid || i__rsp_ready;
    assign accept      = i__rd_valid && o__rd_ready;
    assign consume     = o__rsp_valid && i__rsp_ready;

`ifdef STATE_READER_BYPASS_EN
    assign rd_word = (i__wr_valid && i__wr_addr == i__rd_addr) ? i__wr_data : mem[i__rd_addr];
`else
    assign rd_word = mem[i__rd_addr];
`endif

    // The response register is a snapshot: later writes to the entry never touch it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            o__rsp_valid <= 1'b0;
            o__rsp_data  <= '0;
            o__rsp_count <= '0;
        end else begin
            if (i__wr_valid) mem[i__wr_addr] <= i__wr_data;
            if (accept) begin
                o__rsp_data  <= rd_word;
                o__rsp_valid <= 1'b1;
            end else if (consume) begin
                o__rsp_valid <= 1'b0;
            end
            if (consume) o__rsp_count <= o__rsp_count + 1'b1;
        end
    end
endmodule
